// File: rtl/sprite_move_ctrl.sv
// Player sprite controller: synchronises and debounces four buttons, moves the sprite once per frame with screen clamping.
// Optional build macro DIAG_MOVE_EN resolves the x and y axes independently so diagonal moves are allowed.
module sprite_move_ctrl #(
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int SPRITE_W  = 32,
   parameter int SPRITE_H  = 32,
   parameter int START_X   = 304,
   parameter int START_Y   = 224,
   parameter int STEP      = 4,
   parameter int DB_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       frame_tick,
   input  logic       freeze,
   output logic [9:0] sprite_x,
   output logic [9:0] sprite_y,
   output logic       moving,
   output logic       start
);

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [10:0] STEP_W = 11'(STEP);
   localparam logic [10:0] X_MAX  = 11'(SCREEN_W - SPRITE_W);
   localparam logic [10:0] Y_MAX  = 11'(SCREEN_H - SPRITE_H);

   // Button bit order everywhere: [3]=up [2]=down [1]=left [0]=right
   logic [3:0]         btn_raw_s;
   logic [3:0]         sync1_q, sync2_q;
   logic [3:0]         db_q, db_d, db_prev_q;
   logic [3:0][CW-1:0] cnt_q, cnt_d;
   logic               start_q, start_d;
   logic [9:0]         x_q, x_d, y_q, y_d;
   logic               moving_q, moving_d;

   logic               go_up_s, go_dn_s, go_lt_s, go_rt_s;
   logic [10:0]        x_ext_s, y_ext_s, x_sum_s, y_sum_s;
   logic [10:0]        x_left_s, x_right_s, y_up_s, y_down_s;

   assign btn_raw_s = {btn_up, btn_down, btn_left, btn_right};

   always_comb begin
      db_d  = db_q;
      cnt_d = cnt_q;
      for (int i = 0; i < 4; i++) begin
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
               db_d[i]  = sync2_q[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end else begin
            cnt_d[i] = '0;
         end
      end
   end

   assign start_d = start_q | (|(db_q & ~db_prev_q));

`ifdef DIAG_MOVE_EN
   assign go_up_s = db_q[3] & ~db_q[2];
   assign go_dn_s = db_q[2] & ~db_q[3];
   assign go_lt_s = db_q[1] & ~db_q[0];
   assign go_rt_s = db_q[0] & ~db_q[1];
`else
   assign go_up_s = db_q[3];
   assign go_dn_s = db_q[2] & ~db_q[3];
   assign go_lt_s = db_q[1] & ~db_q[3] & ~db_q[2];
   assign go_rt_s = db_q[0] & ~db_q[3] & ~db_q[2] & ~db_q[1];
`endif

   // 11-bit arithmetic keeps the clamp comparisons free of wrap-around
   assign x_ext_s   = {1'b0, x_q};
   assign y_ext_s   = {1'b0, y_q};
   assign x_sum_s   = x_ext_s + STEP_W;
   assign y_sum_s   = y_ext_s + STEP_W;
   assign x_left_s  = (x_ext_s < STEP_W) ? 11'd0 : (x_ext_s - STEP_W);
   assign y_up_s    = (y_ext_s < STEP_W) ? 11'd0 : (y_ext_s - STEP_W);
   assign x_right_s = (x_sum_s > X_MAX) ? X_MAX : x_sum_s;
   assign y_down_s  = (y_sum_s > Y_MAX) ? Y_MAX : y_sum_s;

   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      moving_d = moving_q;
      if (frame_tick) begin
         if (freeze) begin
            moving_d = 1'b0;
         end else begin
            if (go_up_s) begin
               y_d = y_up_s[9:0];
            end else if (go_dn_s) begin
               y_d = y_down_s[9:0];
            end else begin
               y_d = y_q;
            end
            if (go_lt_s) begin
               x_d = x_left_s[9:0];
            end else if (go_rt_s) begin
               x_d = x_right_s[9:0];
            end else begin
               x_d = x_q;
            end
            moving_d = (x_d != x_q) || (y_d != y_q);
         end
      end else begin
         moving_d = moving_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q   <= 4'b0000;
         sync2_q   <= 4'b0000;
         db_q      <= 4'b0000;
         db_prev_q <= 4'b0000;
         cnt_q     <= '0;
         start_q   <= 1'b0;
         x_q       <= 10'(START_X);
         y_q       <= 10'(START_Y);
         moving_q  <= 1'b0;
      end else begin
         sync1_q   <= btn_raw_s;
         sync2_q   <= sync1_q;
         db_q      <= db_d;
         db_prev_q <= db_q;
         cnt_q     <= cnt_d;
         start_q   <= start_d;
         x_q       <= x_d;
         y_q       <= y_d;
         moving_q  <= moving_d;
      end
   end

   assign sprite_x = x_q;
   assign sprite_y = y_q;
   assign moving   = moving_q;
   assign start    = start_q;

endmodule
